wb_mul_master: RTL

WB_MUL_MASTER -- requirements
Module: wb_mul_master

---
 rtl/wb_mul_master.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_mul_master.sv
// wb_mul_master: Wishbone master that drives one multiply on a memory-mapped multiplier slave.
// Defining WB_MUL_MASTER_WATCHDOG_EN compiles in the ack-timeout / poll-limit abort logic.
module wb_mul_master #(
  parameter logic [31:0] BASE_ADR    = 32'h3000_0000,
  parameter logic [15:0] POLL_MAX    = 16'd1000,
  parameter logic [7:0]  ACK_TIMEOUT = 8'd64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        start_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [63:0] product_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  // state   | meaning
  // IDLE    | waiting for start_i
  // WR_A    | write operand A to BASE+0x0
  // WR_B    | write operand B to BASE+0x4
  // WR_GO   | write 1 to CTRL at BASE+0x8
  // RD_ST   | poll STATUS at BASE+0x8 until bit 0 set
  // RD_PL   | read product low word at BASE+0xC
  // RD_PH   | read product high word at BASE+0x10
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WR_A  = 3'd1;
  localparam logic [2:0] S_WR_B  = 3'd2;
  localparam logic [2:0] S_WR_GO = 3'd3;
  localparam logic [2:0] S_RD_ST = 3'd4;
  localparam logic [2:0] S_RD_PL = 3'd5;
  localparam logic [2:0] S_RD_PH = 3'd6;

  logic [2:0]  r_state;
  logic        r_stb;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic [31:0] r_plo;
  logic [63:0] r_product;
  logic        r_busy;
  logic        r_done;

  logic [31:0] w_req_adr;
  logic        w_req_we;
  logic [31:0] w_req_dat;
  logic        w_ack;
  logic        w_abort;

  assign w_ack = r_stb & wbm_ack_i;

  always_comb begin
    w_req_adr = BASE_ADR;
    w_req_we  = 1'b0;
    w_req_dat = 32'h0;
    case (r_state)
      S_WR_A: begin
        w_req_we  = 1'b1;
        w_req_dat = r_op_a;
      end
      S_WR_B: begin
        w_req_adr = BASE_ADR + 32'h4;
        w_req_we  = 1'b1;
        w_req_dat = r_op_b;
      end
      S_WR_GO: begin
        w_req_adr = BASE_ADR + 32'h8;
        w_req_we  = 1'b1;
        w_req_dat = 32'h1;
      end
      S_RD_ST: w_req_adr = BASE_ADR + 32'h8;
      S_RD_PL: w_req_adr = BASE_ADR + 32'hC;
      S_RD_PH: w_req_adr = BASE_ADR + 32'h10;
      default: ;
    endcase
  end

  // Each bus state spends its entry cycle with stb low, which gives the one-cycle gap between transfers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state   <= S_IDLE;
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
      r_sel     <= 4'h0;
      r_adr     <= 32'h0;
      r_dat     <= 32'h0;
      r_op_a    <= 32'h0;
      r_op_b    <= 32'h0;
      r_plo     <= 32'h0;
      r_product <= 64'h0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_abort) begin
        r_state <= S_IDLE;
        r_stb   <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start_i) begin
              r_op_a  <= op_a_i;
              r_op_b  <= op_b_i;
              r_busy  <= 1'b1;
              r_state <= S_WR_A;
            end
          end
          S_WR_A, S_WR_B, S_WR_GO, S_RD_ST, S_RD_PL, S_RD_PH: begin
            if (!r_stb) begin
              r_stb <= 1'b1;
              r_adr <= w_req_adr;
              r_we  <= w_req_we;
              r_dat <= w_req_dat;
              r_sel <= 4'hF;
            end else if (wbm_ack_i) begin
              r_stb <= 1'b0;
              case (r_state)
                S_WR_A:  r_state <= S_WR_B;
                S_WR_B:  r_state <= S_WR_GO;
                S_WR_GO: r_state <= S_RD_ST;
                S_RD_ST: if (wbm_dat_i[0]) r_state <= S_RD_PL;
                S_RD_PL: begin
                  r_plo   <= wbm_dat_i;
                  r_state <= S_RD_PH;
                end
                S_RD_PH: begin
                  // Low word is staged so an aborted run never disturbs the visible product.
                  r_product <= {wbm_dat_i, r_plo};
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
              endcase
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef WB_MUL_MASTER_WATCHDOG_EN
  logic [7:0]  r_wd_cnt;
  logic [15:0] r_poll_cnt;
  logic        r_err;
  logic        w_ack_tmo;
  logic        w_poll_tmo;

  assign w_ack_tmo  = r_stb & ~wbm_ack_i & (r_wd_cnt == 8'd0);
  assign w_poll_tmo = w_ack & (r_state == S_RD_ST) & ~wbm_dat_i[0] & (r_poll_cnt <= 16'd1);
  assign w_abort    = w_ack_tmo | w_poll_tmo;
  assign err_o      = r_err;

  // Ack timer reloads whenever stb is low, so it measures cycles since this strobe rose.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_wd_cnt   <= 8'd0;
      r_poll_cnt <= 16'd0;
      r_err      <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && start_i) r_err <= 1'b0;
      else if (w_abort)                   r_err <= 1'b1;

      if (!r_stb)                 r_wd_cnt <= ACK_TIMEOUT - 8'd1;
      else if (r_wd_cnt != 8'd0)  r_wd_cnt <= r_wd_cnt - 8'd1;

      if (r_state == S_WR_GO)                  r_poll_cnt <= POLL_MAX;
      else if (w_ack && (r_state == S_RD_ST))  r_poll_cnt <= r_poll_cnt - 16'd1;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{POLL_MAX, ACK_TIMEOUT};
  assign w_abort      = 1'b0;
  assign err_o        = 1'b0;
`endif

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign product_o = r_product;
  assign wbm_cyc_o = r_stb;
  assign wbm_stb_o = r_stb;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;

endmodule
